// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one data-memory request per load/store,
// stalls the front of the pipe until dm_ack or timeout, and drives the MEM/WB register.
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_WB,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic        i_overflow,
  input  logic [31:0] i_result,
  input  logic [31:0] i_BusB,
  input  logic [4:0]  i_Rw,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        o_stall,
  output logic [1:0]  o_WB,
  output logic [31:0] o_rdata,
  output logic [31:0] o_result,
  output logic [4:0]  o_Rw,
  output logic        o_exc
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               dm_req_q, dm_we_q, o_exc_q;
  logic [31:0]        dm_addr_q, dm_wdata_q, o_rdata_q, o_result_q;
  logic [1:0]         o_WB_q;
  logic [4:0]         o_Rw_q;

  logic mem_op, misaligned, exc_op, legal_mem, timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign mem_op      = i_MemRead ^ i_MemWrite;
  assign misaligned  = |i_result[1:0];
  assign exc_op      = i_overflow | (i_MemRead & i_MemWrite) | (mem_op & misaligned);
  assign legal_mem   = mem_op & ~exc_op;
  // The final ACCESS cycle is the one whose edge would bring the count to ACK_TIMEOUT.
  assign timeout_hit = (int'(cnt_q) >= ACK_TIMEOUT - 1);

  assign o_stall = ~rst & (((state_q == IDLE) & legal_mem) |
                           ((state_q == ACCESS) & ~dm_ack & ~timeout_hit));

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      o_WB_q     <= 2'b00;
      o_rdata_q  <= '0;
      o_result_q <= '0;
      o_Rw_q     <= '0;
      o_exc_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (legal_mem) begin
            state_q    <= ACCESS;
            cnt_q      <= '0;
            dm_req_q   <= 1'b1;
            dm_we_q    <= i_MemWrite;
            dm_addr_q  <= i_result;
            dm_wdata_q <= i_BusB;
            o_WB_q     <= 2'b00;
            o_exc_q    <= 1'b0;
          end else begin
            o_WB_q     <= exc_op ? 2'b00 : i_WB;
            o_exc_q    <= exc_op;
            o_result_q <= i_result;
            o_Rw_q     <= i_Rw;
            o_rdata_q  <= '0;
          end
        end
        ACCESS: begin
          if (dm_ack) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dm_req_q   <= 1'b0;
            o_rdata_q  <= dm_we_q ? 32'h0 : dm_rdata;
            o_WB_q     <= i_WB;
            o_result_q <= i_result;
            o_Rw_q     <= i_Rw;
            o_exc_q    <= 1'b0;
          end else if (timeout_hit) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dm_req_q   <= 1'b0;
            o_WB_q     <= 2'b00;
            o_exc_q    <= 1'b1;
          end else begin
            cnt_q      <= sat_inc(cnt_q);
            o_WB_q     <= 2'b00;
            o_exc_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign o_WB     = o_WB_q;
  assign o_rdata  = o_rdata_q;
  assign o_result = o_result_q;
  assign o_Rw     = o_Rw_q;
  assign o_exc    = o_exc_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table, hand-written reset/idle-ack sequences,
// and random ops checked against a transaction-level model.
module tb_mem_access_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_WB;
  logic        i_MemRead, i_MemWrite, i_overflow;
  logic [31:0] i_result, i_BusB;
  logic [4:0]  i_Rw;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ack;
  logic        o_stall;
  logic [1:0]  o_WB;
  logic [31:0] o_rdata, o_result;
  logic [4:0]  o_Rw;
  logic        o_exc;

  int n_asrt = 0;
  int n_fail = 0;

  mem_access_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_WB(i_WB), .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
    .i_overflow(i_overflow), .i_result(i_result), .i_BusB(i_BusB), .i_Rw(i_Rw),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .o_stall(o_stall), .o_WB(o_WB),
    .o_rdata(o_rdata), .o_result(o_result), .o_Rw(o_Rw), .o_exc(o_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic        mr, mw, ovf;
    logic [31:0] res, busb;
    logic [4:0]  rw;
    int          delay;
    logic [31:0] rdata;
    logic [1:0]  exp_wb;
    logic        exp_exc;
    logic [31:0] exp_rdata;
    int          exp_stall;
    int          exp_req;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after a falling edge; memory acks in the ACCESS cycle numbered v.delay (0 = first).
  task automatic run_op(input vec_t v);
    int  n_st = 0;
    int  n_rq = 0;
    bit  done = 0;
    bit  timed_out;
    i_WB = v.wb; i_MemRead = v.mr; i_MemWrite = v.mw; i_overflow = v.ovf;
    i_result = v.res; i_BusB = v.busb; i_Rw = v.rw;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      dm_ack   = dm_req && (n_rq == v.delay);
      dm_rdata = dm_ack ? v.rdata : $urandom;
      @(posedge clk);
      if (o_stall) n_st++;
      if (dm_req) begin
        n_rq++;
        chk("dm_we", 32'(dm_we), 32'(v.mw));
        chk("dm_addr", dm_addr, v.res);
        if (v.mw) chk("dm_wdata", dm_wdata, v.busb);
      end
      done = !o_stall;
      @(negedge clk); #1;
      if (!done) chk("bubble_wb", 32'(o_WB), 32'd0);
    end
    dm_ack = 1'b0;
    if (!done) begin
      n_asrt++; n_fail++;
      $display("FAIL op_complete: stall never released for addr %h", v.res);
    end
    timed_out = (v.exp_req == TO) && (v.delay >= TO);
    chk("stall_cycles", 32'(n_st), 32'(v.exp_stall));
    chk("req_cycles", 32'(n_rq), 32'(v.exp_req));
    chk("req_after", 32'(dm_req), 32'd0);
    chk("o_WB", 32'(o_WB), 32'(v.exp_wb));
    chk("o_exc", 32'(o_exc), 32'(v.exp_exc));
    chk("o_rdata", o_rdata, v.exp_rdata);
    if (!timed_out) begin
      chk("o_result", o_result, v.res);
      chk("o_Rw", 32'(o_Rw), 32'(v.rw));
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t e = v;
    bit exc, legal, tmo;
    int d;
    exc   = v.ovf || (v.mr && v.mw) || ((v.mr ^ v.mw) && (v.res[1:0] != 2'b00));
    legal = (v.mr ^ v.mw) && !exc;
    tmo   = legal && (v.delay >= TO);
    d     = (v.delay < TO - 1) ? v.delay : TO - 1;
    e.exp_exc   = exc || tmo;
    e.exp_wb    = e.exp_exc ? 2'b00 : v.wb;
    e.exp_rdata = (legal && !tmo && v.mr) ? v.rdata : 32'h0;
    e.exp_stall = legal ? d + 1 : 0;
    e.exp_req   = legal ? d + 1 : 0;
    return e;
  endfunction

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{2'b10, 0, 0, 0, 32'h0000_1234, 32'h0, 5'd5,  0,  32'h0,         2'b10, 0, 32'h0,         0,  0};
    tbl[1]  = '{2'b11, 1, 0, 0, 32'h0000_0100, 32'h0, 5'd8,  3,  32'hDEAD_BEEF, 2'b11, 0, 32'hDEAD_BEEF, 4,  4};
    tbl[2]  = '{2'b00, 0, 1, 0, 32'h0000_0104, 32'hA5A5_A5A5, 5'd0, 0, 32'h1111_1111, 2'b00, 0, 32'h0, 1, 1};
    tbl[3]  = '{2'b11, 1, 0, 0, 32'h0000_0102, 32'h0, 5'd9,  0,  32'h0,         2'b00, 1, 32'h0,         0,  0};
    tbl[4]  = '{2'b11, 1, 0, 0, 32'h0000_0200, 32'h0, 5'd3,  99, 32'h0,         2'b00, 1, 32'h0,         16, 16};
    tbl[5]  = '{2'b10, 0, 0, 1, 32'h7FFF_FFFF, 32'h0, 5'd4,  0,  32'h0,         2'b00, 1, 32'h0,         0,  0};
    tbl[6]  = '{2'b11, 1, 1, 0, 32'h0000_0010, 32'h0, 5'd6,  0,  32'h0,         2'b00, 1, 32'h0,         0,  0};
    tbl[7]  = '{2'b11, 1, 0, 1, 32'h0000_0020, 32'h0, 5'd7,  0,  32'h0,         2'b00, 1, 32'h0,         0,  0};
    tbl[8]  = '{2'b10, 0, 0, 0, 32'h0000_0ABC, 32'h0, 5'd10, 0,  32'h0,         2'b10, 0, 32'h0,         0,  0};
    tbl[9]  = '{2'b00, 0, 1, 0, 32'h0000_0101, 32'h5, 5'd0,  0,  32'h0,         2'b00, 1, 32'h0,         0,  0};
    tbl[10] = '{2'b11, 1, 0, 0, 32'h0000_0400, 32'h0, 5'd12, 15, 32'h1234_5678, 2'b11, 0, 32'h1234_5678, 16, 16};

    rst = 1'b1; dm_ack = 1'b0; dm_rdata = '0;
    i_WB = 2'b11; i_MemRead = 1'b1; i_MemWrite = 1'b0; i_overflow = 1'b0;
    i_result = 32'h100; i_BusB = '0; i_Rw = 5'd1;
    @(negedge clk); #1;
    @(posedge clk);
    chk("rst_stall", 32'(o_stall), 32'd0);
    @(negedge clk); #1;
    chk("rst_req", 32'(dm_req), 32'd0);
    chk("rst_wb", 32'(o_WB), 32'd0);
    chk("rst_exc", 32'(o_exc), 32'd0);
    chk("rst_result", o_result, 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i]);

    // dm_ack while idle must not leak into the writeback
    i_WB = 2'b10; i_MemRead = 1'b0; i_MemWrite = 1'b0; i_result = 32'h77; i_Rw = 5'd2;
    dm_ack = 1'b1; dm_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    chk("idle_ack_stall", 32'(o_stall), 32'd0);
    @(negedge clk); #1;
    dm_ack = 1'b0;
    chk("idle_ack_req", 32'(dm_req), 32'd0);
    chk("idle_ack_rdata", o_rdata, 32'd0);
    chk("idle_ack_wb", 32'(o_WB), 32'(2'b10));

    // reset in the second ACCESS cycle, then a late ack
    i_WB = 2'b11; i_MemRead = 1'b1; i_result = 32'h300; i_Rw = 5'd3;
    @(negedge clk); #1;
    chk("rs_req1", 32'(dm_req), 32'd1);
    @(negedge clk); #1;
    chk("rs_req2", 32'(dm_req), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    chk("rs_stall", 32'(o_stall), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    chk("rs_req", 32'(dm_req), 32'd0);
    chk("rs_we", 32'(dm_we), 32'd0);
    chk("rs_addr", dm_addr, 32'd0);
    chk("rs_wdata", dm_wdata, 32'd0);
    chk("rs_wb", 32'(o_WB), 32'd0);
    chk("rs_rdata", o_rdata, 32'd0);
    chk("rs_result", o_result, 32'd0);
    chk("rs_rw", 32'(o_Rw), 32'd0);
    chk("rs_exc", 32'(o_exc), 32'd0);
    i_WB = 2'b10; i_MemRead = 1'b0; i_result = 32'h55; i_Rw = 5'd7;
    @(negedge clk); #1;
    dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    chk("late_ack_stall", 32'(o_stall), 32'd0);
    chk("late_ack_req", 32'(dm_req), 32'd0);
    @(negedge clk); #1;
    dm_ack = 1'b0;
    chk("late_ack_rdata", o_rdata, 32'd0);
    chk("late_ack_wb", 32'(o_WB), 32'(2'b10));
    chk("late_ack_result", o_result, 32'h55);

    for (int n = 0; n < 60; n++) begin
      vec_t v;
      int k = $urandom_range(0, 9);
      v.wb    = 2'($urandom);
      v.mr    = (k < 4) || (k == 9);
      v.mw    = (k >= 4 && k < 7) || (k == 9);
      v.ovf   = ($urandom_range(0, 9) == 0);
      v.res   = $urandom & ~32'h3;
      if ($urandom_range(0, 5) == 0) v.res[1:0] = 2'($urandom_range(1, 3));
      v.busb  = $urandom;
      v.rw    = 5'($urandom);
      v.delay = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 4) : $urandom_range(0, 5);
      v.rdata = $urandom;
      run_op(model(v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16, meaning the maximum number of ACCESS cycles to wait for dm_ack before aborting.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates occur on the falling edge of clk, as in the pipeline registers.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_WB  in  2  writeback control from the EX/MEM register: bit1 = RegWrite, bit0 = MemtoReg.
REQ-005 SHALL have port i_MemRead  in  1  load request.
REQ-006 SHALL have port i_MemWrite  in  1  store request.
REQ-007 SHALL have port i_overflow  in  1  ALU overflow flag from EX.
REQ-008 SHALL have port i_result  in  32  ALU result, which is also the memory address.
REQ-009 SHALL have port i_BusB  in  32  store data.
REQ-010 SHALL have port i_Rw  in  5  destination register.
REQ-011 SHALL have port dm_req  out  1  data-memory request, driven from a register.
REQ-012 SHALL have port dm_we  out  1  write enable: 1 = store.
REQ-013 SHALL have port dm_addr  out  32  memory address.
REQ-014 SHALL have port dm_wdata  out  32  write data.
REQ-015 SHALL have port dm_rdata  in  32  read data, valid while dm_ack = 1.
REQ-016 SHALL have port dm_ack  in  1  memory completion strobe.
REQ-017 SHALL have port o_stall  out  1  combinational hold request to IF/ID/EX and the EX/MEM register.
REQ-018 SHALL have ports o_WB (2), o_rdata (32), o_result (32), o_Rw (5) and o_exc (1) as registered outputs; together they form the MEM/WB register.

Function
REQ-019 SHALL implement a two-state FSM with states IDLE and ACCESS.
REQ-020 An op is a mem op when i_MemRead xor i_MemWrite is 1; it is legal when i_result[1:0] = 00 and i_overflow = 0.
REQ-021 IDLE with no mem op: at each edge, o_WB <= i_WB, o_result <= i_result, o_Rw <= i_Rw, o_rdata <= 0, o_exc <= 0; no stall, so latency is 1 edge.
REQ-022 IDLE with a legal mem op: o_stall = 1; at the edge, go to ACCESS, dm_req <= 1, and capture dm_addr <= i_result, dm_we <= i_MemWrite, dm_wdata <= i_BusB; o_WB <= 00 (bubble).
REQ-023 IDLE with an illegal op (misaligned, overflow, or i_MemRead & i_MemWrite both set): no request; at the edge, o_WB <= 00, o_exc <= 1, o_Rw and o_result pass through; no stall.
REQ-024 Any op with i_overflow = 1 (mem or not) SHALL be suppressed: o_WB <= 00 and o_exc <= 1.
REQ-025 ACCESS: dm_req, dm_addr, dm_we and dm_wdata SHALL be held stable; o_stall = !dm_ack; each edge without dm_ack inserts a bubble (o_WB <= 00) and increments the timeout counter.
REQ-026 ACCESS with dm_ack = 1 at the edge: o_rdata <= dm_rdata on a load, 0 on a store; o_WB <= i_WB; o_result <= i_result; o_Rw <= i_Rw; dm_req <= 0; go to IDLE; clear the counter. The EX/MEM register advances on the same edge.
REQ-027 Minimum mem-op latency SHALL be 2 edges (dm_ack in the first ACCESS cycle).
REQ-028 Timeout: when the counter reaches ACK_TIMEOUT without dm_ack, then at that edge dm_req <= 0, o_WB <= 00, o_exc <= 1, go to IDLE; o_stall = 0 in that cycle.
REQ-029 dm_ack while in IDLE SHALL be ignored.
REQ-030 o_exc SHALL be a one-cycle pulse, cleared on the next edge unless a new exception occurs.
REQ-031 The timeout counter SHALL saturate and never wrap.

Reset
REQ-032 rst = 1 at an edge SHALL force: state IDLE, counter 0, dm_req/dm_we 0, dm_addr/dm_wdata 0, o_WB 00, o_rdata/o_result 0, o_Rw 0, o_exc 0.
REQ-033 rst during ACCESS SHALL abandon the transaction; a dm_ack arriving afterwards SHALL be ignored.
REQ-034 o_stall SHALL be 0 while rst = 1.

Verification
REQ-035 ALU op: i_WB=10, i_result=0x00001234, i_Rw=5 -> after 1 edge o_WB=10, o_result=0x00001234, o_Rw=5; o_stall stays 0.
REQ-036 Load at 0x00000100, dm_ack 3 cycles after dm_req rises, dm_rdata=0xDEADBEEF -> dm_we=0; o_stall high for 4 cycles; bubbles o_WB=00 meanwhile; then o_rdata=0xDEADBEEF, o_WB=11.
REQ-037 Store at 0x00000104, data 0xA5A5A5A5, dm_ack in the first ACCESS cycle -> dm_we=1, dm_wdata=0xA5A5A5A5; o_stall high for 1 cycle; o_WB=00.
REQ-038 Load at 0x00000102 -> dm_req never rises; o_exc=1 for one cycle; o_WB=00; o_stall=0.
REQ-039 Load with no dm_ack, ACK_TIMEOUT=16 -> dm_req drops after 16 ACCESS cycles; o_exc pulses; FSM returns to IDLE.
REQ-040 rst in the 2nd ACCESS cycle, then dm_ack 2 cycles later -> all outputs 0 after the reset edge; the late dm_ack causes no writeback.
